flag_branch_unit: RTL and testbench

Condition-flag register and branch-resolution unit for the 16-bit WISC pipeline. It captures Z/V/N from the EX-stage ALU result (saturating add/sub, XOR, shifts) according to the opcode that produced it. It then evaluates the 3-bit branch condition of B/BR instructions in ID, with a same-cycle bypass of the flags being written. A small run/halt state machine freezes all flag updates after HLT retires through EX.

---
 rtl/flag_branch_unit.sv | 104 ++++++++++
 tb/tb_flag_branch_unit.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/flag_branch_unit.sv
// Condition-flag register and branch resolution for the 16-bit WISC pipeline.
// Flags are captured from EX per opcode; ID branches see the flags being written this cycle.
module flag_branch_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [3:0]  ex_opcode,
    input  logic [15:0] ex_result,
    input  logic        ex_ovfl,
    input  logic        stall,
    input  logic        flush,
    input  logic        id_br_valid,
    input  logic [2:0]  id_ccc,
    output logic        flag_z,
    output logic        flag_v,
    output logic        flag_n,
    output logic        br_taken,
    output logic        halted
);

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t state_r;
    state_t state_nxt_s;
    logic   we_s;
    logic   z_nxt_s;
    logic   v_nxt_s;
    logic   n_nxt_s;
    logic   cond_s;

    function automatic logic eval_cond(input logic [2:0] ccc, input logic z, input logic n,
                                       input logic v);
        logic taken;
        case (ccc)
            3'b000:  taken = ~z;
            3'b001:  taken = z;
            3'b010:  taken = ~z & ~n;
            3'b011:  taken = n;
            3'b100:  taken = z | (~z & ~n);
            3'b101:  taken = n | z;
            3'b110:  taken = v;
            3'b111:  taken = 1'b1;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

    assign we_s = ex_valid & ~stall & ~flush & (state_r == ST_RUN);

    // Next-state flags and run/halt state; also feeds the same-cycle branch bypass.
    always_comb begin
        z_nxt_s     = flag_z;
        v_nxt_s     = flag_v;
        n_nxt_s     = flag_n;
        state_nxt_s = state_r;
        if (we_s) begin
            case (ex_opcode)
                4'b0000, 4'b0001: begin
                    z_nxt_s = (ex_result == 16'h0000);
                    n_nxt_s = ex_result[15];
                    v_nxt_s = ex_ovfl;
                end
                4'b0010, 4'b0100, 4'b0101, 4'b0110: begin
                    z_nxt_s = (ex_result == 16'h0000);
                end
                4'b1111: begin
                    state_nxt_s = ST_HALTED;
                end
                default: begin
                    z_nxt_s = flag_z;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Branch decision from next-state flags, gated by a real branch in ID.
    always_comb begin
        cond_s   = eval_cond(id_ccc, z_nxt_s, n_nxt_s, v_nxt_s);
        br_taken = id_br_valid & cond_s;
    end

    // Architectural flag and halt registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_RUN;
            flag_z  <= 1'b0;
            flag_v  <= 1'b0;
            flag_n  <= 1'b0;
            halted  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            flag_z  <= z_nxt_s;
            flag_v  <= v_nxt_s;
            flag_n  <= n_nxt_s;
            halted  <= (state_nxt_s == ST_HALTED);
        end
    end

endmodule

// File: tb/tb_flag_branch_unit.sv
// Directed self-checking bench for flag_branch_unit.
module tb_flag_branch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [3:0]  ex_opcode;
    logic [15:0] ex_result;
    logic        ex_ovfl;
    logic        stall;
    logic        flush;
    logic        id_br_valid;
    logic [2:0]  id_ccc;
    logic        flag_z;
    logic        flag_v;
    logic        flag_n;
    logic        br_taken;
    logic        halted;

    int errors = 0;
    int checks = 0;

    flag_branch_unit dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_opcode(ex_opcode),
        .ex_result(ex_result), .ex_ovfl(ex_ovfl), .stall(stall), .flush(flush),
        .id_br_valid(id_br_valid), .id_ccc(id_ccc), .flag_z(flag_z), .flag_v(flag_v),
        .flag_n(flag_n), .br_taken(br_taken), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ex_valid = 1'b0; ex_opcode = 4'h0; ex_result = 16'h0000; ex_ovfl = 1'b0;
        stall = 1'b0; flush = 1'b0; id_br_valid = 1'b0; id_ccc = 3'b000;
    endtask

    task automatic ex(input logic [3:0] op, input logic [15:0] res, input logic ov);
        ex_valid = 1'b1; ex_opcode = op; ex_result = res; ex_ovfl = ov;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({flag_z, flag_n, flag_v, halted} !== 4'b0000) begin
            $display("FAIL reset_state got znvh=%b want 0000", {flag_z, flag_n, flag_v, halted});
            errors++;
        end
    endtask

    task automatic test_add_zero();
        ex(4'h0, 16'h0000, 1'b0);
        id_br_valid = 1'b1; id_ccc = 3'b001;
        #1;
        checks++;
        if (br_taken !== 1'b1) begin
            $display("FAIL add_zero_bypass_eq got %b want 1", br_taken); errors++;
        end
        step(); idle();
        checks++;
        if ({flag_z, flag_n, flag_v} !== 3'b100) begin
            $display("FAIL add_zero_flags got znv=%b want 100", {flag_z, flag_n, flag_v}); errors++;
        end
    endtask

    task automatic test_sub_neg();
        ex(4'h1, 16'h8000, 1'b1);
        id_br_valid = 1'b1;
        id_ccc = 3'b110; #1;
        checks++;
        if (br_taken !== 1'b1) begin $display("FAIL sub_ov got %b want 1", br_taken); errors++; end
        id_ccc = 3'b010; #1;
        checks++;
        if (br_taken !== 1'b0) begin $display("FAIL sub_gt got %b want 0", br_taken); errors++; end
        id_ccc = 3'b101; #1;
        checks++;
        if (br_taken !== 1'b1) begin $display("FAIL sub_lte got %b want 1", br_taken); errors++; end
        step(); idle();
        checks++;
        if ({flag_z, flag_n, flag_v} !== 3'b011) begin
            $display("FAIL sub_flags got znv=%b want 011", {flag_z, flag_n, flag_v}); errors++;
        end
    endtask

    task automatic test_zonly();
        // XOR of zero sets Z while N and V stay from the SUB.
        ex(4'h2, 16'h0000, 1'b0);
        id_br_valid = 1'b1; id_ccc = 3'b001; #1;
        checks++;
        if (br_taken !== 1'b1) begin $display("FAIL xor0_eq got %b want 1", br_taken); errors++; end
        step();
        checks++;
        if ({flag_z, flag_n, flag_v} !== 3'b111) begin
            $display("FAIL xor0_flags got znv=%b want 111", {flag_z, flag_n, flag_v}); errors++;
        end
        ex(4'h2, 16'h0005, 1'b0); id_br_valid = 1'b0;
        step();
        checks++;
        if ({flag_z, flag_n, flag_v} !== 3'b011) begin
            $display("FAIL xor5_flags got znv=%b want 011", {flag_z, flag_n, flag_v}); errors++;
        end
        ex(4'h7, 16'h0000, 1'b0);
        id_br_valid = 1'b1; id_ccc = 3'b001; #1;
        checks++;
        if (br_taken !== 1'b0) begin $display("FAIL paddsb_eq got %b want 0", br_taken); errors++; end
        step(); idle();
        checks++;
        if ({flag_z, flag_n, flag_v} !== 3'b011) begin
            $display("FAIL paddsb_flags got znv=%b want 011", {flag_z, flag_n, flag_v}); errors++;
        end
    endtask

    task automatic test_stall_flush();
        for (int k = 0; k < 2; k++) begin
            ex(4'h0, 16'h0000, 1'b0);
            stall = (k == 0); flush = (k == 1);
            id_br_valid = 1'b1; id_ccc = 3'b001; #1;
            checks++;
            if (br_taken !== 1'b0) begin
                $display("FAIL blocked%0d_eq got %b want 0", k, br_taken); errors++;
            end
            step(); idle();
            checks++;
            if ({flag_z, flag_n, flag_v} !== 3'b011) begin
                $display("FAIL blocked%0d_flags got znv=%b want 011", k, {flag_z, flag_n, flag_v});
                errors++;
            end
        end
    endtask

    task automatic test_pos_sat();
        ex(4'h0, 16'h7FFF, 1'b1);
        id_br_valid = 1'b1; id_ccc = 3'b010; #1;
        checks++;
        if (br_taken !== 1'b1) begin $display("FAIL sat_gt got %b want 1", br_taken); errors++; end
        id_ccc = 3'b011; #1;
        checks++;
        if (br_taken !== 1'b0) begin $display("FAIL sat_lt got %b want 0", br_taken); errors++; end
        step(); idle();
        checks++;
        if ({flag_z, flag_n, flag_v} !== 3'b001) begin
            $display("FAIL sat_flags got znv=%b want 001", {flag_z, flag_n, flag_v}); errors++;
        end
    endtask

    task automatic test_halt();
        ex(4'hF, 16'h0000, 1'b0); flush = 1'b1;
        step(); idle();
        checks++;
        if (halted !== 1'b0) begin $display("FAIL flushed_hlt got %b want 0", halted); errors++; end
        ex(4'hF, 16'h0000, 1'b0);
        step(); idle();
        checks++;
        if (halted !== 1'b1) begin $display("FAIL hlt got %b want 1", halted); errors++; end
        ex(4'h0, 16'h0000, 1'b0);
        id_br_valid = 1'b1; id_ccc = 3'b001; #1;
        checks++;
        if (br_taken !== 1'b0) begin $display("FAIL halted_eq got %b want 0", br_taken); errors++; end
        step();
        checks++;
        if ({flag_z, flag_n, flag_v, halted} !== 4'b0011) begin
            $display("FAIL halted_flags got znvh=%b want 0011", {flag_z, flag_n, flag_v, halted});
            errors++;
        end
        ex(4'h0, 16'h8000, 1'b1); rst = 1'b1;
        step(); rst = 1'b0; idle();
        checks++;
        if ({flag_z, flag_n, flag_v, halted} !== 4'b0000) begin
            $display("FAIL rst_halted got znvh=%b want 0000", {flag_z, flag_n, flag_v, halted});
            errors++;
        end
        ex(4'h0, 16'h0000, 1'b0);
        step(); idle();
        checks++;
        if ({flag_z, flag_n, flag_v} !== 3'b100) begin
            $display("FAIL run_after_rst got znv=%b want 100", {flag_z, flag_n, flag_v}); errors++;
        end
    endtask

    task automatic test_uncond();
        // Flags are Z=1 N=0 V=0 here.
        id_br_valid = 1'b0; id_ccc = 3'b111; #1;
        checks++;
        if (br_taken !== 1'b0) begin $display("FAIL nobr_uncond got %b want 0", br_taken); errors++; end
        id_ccc = 3'b001; #1;
        checks++;
        if (br_taken !== 1'b0) begin $display("FAIL nobr_eq got %b want 0", br_taken); errors++; end
        id_br_valid = 1'b1; id_ccc = 3'b100; #1;
        checks++;
        if (br_taken !== 1'b1) begin $display("FAIL gte_z got %b want 1", br_taken); errors++; end
        id_ccc = 3'b000; #1;
        checks++;
        if (br_taken !== 1'b0) begin $display("FAIL ne_z got %b want 0", br_taken); errors++; end
        id_ccc = 3'b111; #1;
        checks++;
        if (br_taken !== 1'b1) begin $display("FAIL uncond_z got %b want 1", br_taken); errors++; end
        ex(4'h1, 16'h8000, 1'b1); #1;
        checks++;
        if (br_taken !== 1'b1) begin $display("FAIL uncond_nv got %b want 1", br_taken); errors++; end
        id_ccc = 3'b100; #1;
        checks++;
        if (br_taken !== 1'b0) begin $display("FAIL gte_n got %b want 0", br_taken); errors++; end
        step(); idle();
    endtask

    initial begin
        rst = 1'b0;
        idle();
        test_reset();
        test_add_zero();
        test_sub_neg();
        test_zonly();
        test_stall_flush();
        test_pos_sat();
        test_halt();
        test_uncond();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
